// File: rtl/sd_cmd_ctrl.sv
// SD card command-line controller: divided card clock, 48-bit command framing
// with CRC7, and optional 48-bit response capture with timeout and CRC check.
module sd_cmd_ctrl #(
  parameter int HALF_DIV     = 15,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [5:0]  CMD_IDX,
  input  logic [31:0] CMD_ARG,
  input  logic        RESP_EXP,
  input  logic        CRC_CHK,
  output logic        SD_CLK,
  output logic        CMD_OUT,
  output logic        CMD_OE,
  input  logic        CMD_IN,
  output logic        BUSY,
  output logic        DONE,
  output logic        TIMEOUT,
  output logic        CRC_ERR,
  output logic [5:0]  RESP_IDX,
  output logic [31:0] RESP
);

  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FIN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          tc, rise_tick, fall_tick;
  logic [39:0]   tx_sr;
  logic [37:0]   rx_sr;
  logic [6:0]    crc;
  logic          crc_bad;
  logic [5:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          resp_exp, crc_chk;

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  // Card clock free-runs regardless of state; ticks mark the CLK cycle whose
  // closing edge flips SD_CLK.
  assign tc        = (div_cnt == DW'(HALF_DIV - 1));
  assign rise_tick = tc & ~SD_CLK;
  assign fall_tick = tc & SD_CLK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      SD_CLK  <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      SD_CLK  <= ~SD_CLK;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (START) state_nxt = SEND;
      SEND: if (fall_tick && bit_cnt == 6'd48) state_nxt = resp_exp ? WAIT : FIN;
      WAIT: if (rise_tick) begin
        if (!CMD_IN)                               state_nxt = RECV;
        else if (to_cnt == TW'(RESP_TIMEOUT - 1))  state_nxt = FIN;
      end
      RECV: if (rise_tick && bit_cnt == 6'd47) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);
  assign DONE = (state == FIN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CMD_OUT  <= 1'b1;
      CMD_OE   <= 1'b0;
      TIMEOUT  <= 1'b0;
      CRC_ERR  <= 1'b0;
      RESP     <= '0;
      RESP_IDX <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      crc      <= '0;
      crc_bad  <= 1'b0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      resp_exp <= 1'b0;
      crc_chk  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          tx_sr    <= {2'b01, CMD_IDX, CMD_ARG};
          resp_exp <= RESP_EXP;
          crc_chk  <= CRC_CHK;
          TIMEOUT  <= 1'b0;
          CRC_ERR  <= 1'b0;
          crc      <= '0;
          bit_cnt  <= '0;
          CMD_OE   <= 1'b1;
        end
        SEND: if (fall_tick) begin
          // CRC accumulates serially as the 40 header bits go out, then is
          // shifted out behind them.
          if (bit_cnt < 6'd40) begin
            CMD_OUT <= tx_sr[39];
            tx_sr   <= {tx_sr[38:0], 1'b0};
            crc     <= crc_step(crc, tx_sr[39]);
            bit_cnt <= bit_cnt + 1'b1;
          end else if (bit_cnt < 6'd47) begin
            CMD_OUT <= crc[6];
            crc     <= {crc[5:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (bit_cnt == 6'd47) begin
            CMD_OUT <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            CMD_OUT <= 1'b1;
            CMD_OE  <= 1'b0;
            bit_cnt <= '0;
            to_cnt  <= '0;
            crc     <= '0;
            crc_bad <= 1'b0;
          end
        end
        WAIT: if (rise_tick) begin
          // Start bit is a 0, which leaves the zero CRC seed unchanged.
          if (!CMD_IN)                              bit_cnt <= 6'd1;
          else if (to_cnt == TW'(RESP_TIMEOUT - 1)) TIMEOUT <= 1'b1;
          else                                      to_cnt  <= to_cnt + 1'b1;
        end
        RECV: if (rise_tick) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt < 6'd40) begin
            rx_sr <= {rx_sr[36:0], CMD_IN};
            crc   <= crc_step(crc, CMD_IN);
          end else if (bit_cnt < 6'd47) begin
            crc_bad <= crc_bad | (CMD_IN ^ crc[6]);
            crc     <= {crc[5:0], 1'b0};
          end else begin
            RESP_IDX <= rx_sr[37:32];
            RESP     <= rx_sr[31:0];
            CRC_ERR  <= (crc_chk & crc_bad) | ~CMD_IN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
